// File: rtl/fifo_stream_out.sv
// fifo_stream_out: drains a synchronous FIFO via pop/dout and re-presents the
// words as a valid/ready stream. A two-entry head/tail buffer absorbs the
// FIFO's one-cycle read latency so one beat per cycle is sustained under
// backpressure.
module fifo_stream_out #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    fifo_dout,
    output logic             fifo_pop,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [CNT_W-1:0] beat_cnt
);

    // Buffer occupancy (0..2), pop-in-flight flag and discard flag
    logic [1:0]    occ;
    logic          inflight;
    logic          drop;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;

    logic          xfer;
    logic          capture;
    logic [2:0]    fill;
    logic [1:0]    slot;

    assign m_valid = (occ != 2'd0);
    assign m_data  = m_valid ? head : '0;
    assign xfer    = m_valid && m_ready;

    // A returning word is kept unless it was marked for discard or a flush
    // is emptying the buffer on this very edge.
    assign capture = inflight && !drop && !flush;

    // Entries that will be held (buffered + returning) after this edge if no
    // new pop were issued; popping is allowed only while that stays below 2.
    // When xfer is high occ is at least 1, so the subtraction cannot wrap.
    assign fill     = 3'(occ) + 3'(inflight) - 3'(xfer);
    assign fifo_pop = rstn && !fifo_empty && !flush && (fill < 3'd2);

    // Buffer position the captured word lands in, after any same-edge pop of
    // the head has shifted the tail forward.
    assign slot = occ - 2'(xfer);

    // Control state: occupancy, in-flight/discard flags and beat counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            drop     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            inflight <= fifo_pop;
            if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (flush) begin
                occ  <= 2'd0;
                drop <= inflight;
            end else begin
                occ  <= occ + 2'(capture) - 2'(xfer);
                drop <= 1'b0;
            end
        end
    end

    // Data storage: shift tail to head on a pop, then write the returning word
    always_ff @(posedge clk) begin
        if (xfer && (occ == 2'd2)) begin
            head <= tail;
        end
        if (capture) begin
            if (slot == 2'd0) begin
                head <= fifo_dout;
            end else begin
                tail <= fifo_dout;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_out.sv
// tb_fifo_stream_out: directed bench for fifo_stream_out with a behavioural
// synchronous FIFO (one-cycle read latency) feeding the block.
module tb_fifo_stream_out;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout = 8'd0;
    logic        fifo_pop;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic [15:0] beat_cnt;

    // Narrow-counter instance sharing the same stimulus for the wrap check
    logic        fifo_pop4;
    logic        m_valid4;
    logic [7:0]  m_data4;
    logic [3:0]  beat_cnt4;

    fifo_stream_out #(.DW(8), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_pop(fifo_pop), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .beat_cnt(beat_cnt)
    );

    fifo_stream_out #(.DW(8), .CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_pop(fifo_pop4), .flush(flush), .m_valid(m_valid4), .m_ready(m_ready),
        .m_data(m_data4), .beat_cnt(beat_cnt4)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_pops = 0;
    int         n_bad_pop = 0;
    logic [7:0] q[$];
    logic [7:0] rx[$];
    logic       s_pop;
    logic       s_valid;
    logic [7:0] s_data;

    // Expected per-cycle traces
    logic       t1_pop  [7]  = '{1, 1, 1, 1, 0, 0, 0};
    logic       t1_vld  [7]  = '{0, 0, 1, 1, 1, 1, 0};
    logic [7:0] t1_dat  [7]  = '{0, 0, 10, 11, 12, 13, 0};
    logic       t2_pop  [11] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    logic       t2_vld  [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] t2_dat  [11] = '{0, 0, 10, 10, 10, 10, 10, 11, 12, 13, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, then emulate the FIFO read
    task automatic tick();
        @(negedge clk);
        s_pop   = fifo_pop;
        s_valid = m_valid;
        s_data  = m_data;
        if (fifo_pop && fifo_empty) n_bad_pop++;
        if (fifo_pop) n_pops++;
        if (m_valid && m_ready) rx.push_back(m_data);
        @(posedge clk);
        #1;
        if (s_pop && q.size() > 0) fifo_dout = q.pop_front();
        fifo_empty = (q.size() == 0);
    endtask

    task automatic restart(input int first, input int count);
        rstn = 1'b0;
        flush = 1'b0;
        m_ready = 1'b0;
        q.delete();
        fifo_empty = 1'b1;
        tick();
        tick();
        for (int i = 0; i < count; i++) q.push_back(8'(first + i));
        fifo_empty = (q.size() == 0);
        rx.delete();
        n_pops = 0;
        n_bad_pop = 0;
        rstn = 1'b1;
    endtask

    task automatic chk_rx(input string tag, input int first, input int count);
        chk({tag, "_n"}, 32'(rx.size()), 32'(count));
        for (int i = 0; i < count; i++)
            chk({tag, "_d"}, (rx.size() > i) ? 32'(rx[i]) : 32'hFFFF, 32'(first + i));
    endtask

    initial begin
        // Reset state with a non-empty FIFO
        tick();
        q.push_back(8'd99);
        fifo_empty = 1'b0;
        #1;
        chk("rst_pop", 32'(fifo_pop), 0);
        chk("rst_vld", 32'(m_valid), 0);
        chk("rst_dat", 32'(m_data), 0);
        chk("rst_cnt", 32'(beat_cnt), 0);

        // 1: streaming with m_ready held high
        restart(10, 4);
        m_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("t1_pop", 32'(s_pop), 32'(t1_pop[k]));
            chk("t1_vld", 32'(s_valid), 32'(t1_vld[k]));
            chk("t1_dat", 32'(s_data), 32'(t1_dat[k]));
        end
        chk("t1_cnt", 32'(beat_cnt), 4);

        // 2: backpressure then release
        restart(10, 4);
        for (int k = 0; k < 11; k++) begin
            m_ready = (k >= 6);
            tick();
            chk("t2_pop", 32'(s_pop), 32'(t2_pop[k]));
            chk("t2_vld", 32'(s_valid), 32'(t2_vld[k]));
            chk("t2_dat", 32'(s_data), 32'(t2_dat[k]));
        end
        chk("t2_npop", 32'(n_pops), 4);
        chk("t2_cnt", 32'(beat_cnt), 4);

        // 3: alternating ready
        restart(10, 4);
        for (int k = 0; k < 14; k++) begin
            m_ready = (k % 2 == 0);
            tick();
        end
        chk_rx("t3_rx", 10, 4);
        chk("t3_cnt", 32'(beat_cnt), 4);
        chk("t3_badpop", 32'(n_bad_pop), 0);
        chk("t3_npop", 32'(n_pops), 4);

        // 4: flush one cycle after the first pop
        restart(10, 4);
        m_ready = 1'b1;
        tick();
        chk("t4_pop0", 32'(s_pop), 1);
        flush = 1'b1;
        tick();
        chk("t4_popf", 32'(s_pop), 0);
        flush = 1'b0;
        tick();
        chk("t4_vld2", 32'(s_valid), 0);
        chk("t4_pop2", 32'(s_pop), 1);
        for (int k = 0; k < 8; k++) tick();
        chk_rx("t4_rx", 11, 3);
        chk("t4_cnt", 32'(beat_cnt), 3);

        // 5: counter wrap on the narrow instance
        restart(0, 17);
        m_ready = 1'b1;
        for (int k = 0; k < 25; k++) tick();
        chk("t5_cnt16", 32'(beat_cnt), 17);
        chk("t5_cnt4", 32'(beat_cnt4), 1);
        chk_rx("t5_rx", 0, 17);

        // 6: asynchronous reset while the buffer is full
        restart(10, 6);
        for (int k = 0; k < 5; k++) begin
            m_ready = (k < 3);
            tick();
        end
        chk("t6_pre_pop", 32'(s_pop), 0);
        chk("t6_pre_vld", 32'(s_valid), 1);
        chk("t6_pre_dat", 32'(s_data), 11);
        chk("t6_pre_cnt", 32'(beat_cnt), 1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_vld", 32'(m_valid), 0);
        chk("t6_rst_dat", 32'(m_data), 0);
        chk("t6_rst_cnt", 32'(beat_cnt), 0);
        chk("t6_rst_pop", 32'(fifo_pop), 0);
        tick();
        tick();
        chk("t6_qleft", 32'(q.size()), 3);
        rx.delete();
        rstn = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk_rx("t6_rx", 13, 3);
        chk("t6_cnt", 32'(beat_cnt), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
